// File: rtl/enable_div.sv
// Programmable clock-enable generator: one-cycle o_en strobe every i_tc+1 cycles,
// with a shadowed terminal count, pause control, divided square wave and phase count.
module enable_div #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             i_sclr_n,
  input  logic [WIDTH-1:0] i_tc,
  input  logic             i_load,
  input  logic             i_run,
  output logic             o_en,
  output logic             o_sq,
  output logic [WIDTH-1:0] o_cnt
);

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_tc_q;
  logic             r_sq;
  logic             w_term;

  assign w_term = (r_cnt == r_tc_q);

  // Strobe is combinational so a pause suppresses it in the same cycle.
  assign o_en  = w_term & i_run;
  assign o_sq  = r_sq;
  assign o_cnt = r_cnt;

  // Wrap is an explicit clear at the active terminal count; i_tc is only sampled at wrap/load.
  always_ff @(posedge clk) begin
    if (!i_sclr_n) begin
      r_cnt  <= '0;
      r_tc_q <= i_tc;
      r_sq   <= 1'b0;
    end else if (i_load) begin
      r_cnt  <= '0;
      r_tc_q <= i_tc;
    end else if (i_run) begin
      if (w_term) begin
        r_cnt  <= '0;
        r_tc_q <= i_tc;
        r_sq   <= ~r_sq;
      end else begin
        r_cnt  <= r_cnt + WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_enable_div.sv
// Directed self-checking bench for enable_div (WIDTH=4).
module tb_enable_div;

  localparam int unsigned WIDTH = 4;

  logic             clk;
  logic             i_sclr_n;
  logic [WIDTH-1:0] i_tc;
  logic             i_load;
  logic             i_run;
  logic             o_en;
  logic             o_sq;
  logic [WIDTH-1:0] o_cnt;

  int n_checks;
  int n_fail;

  enable_div #(.WIDTH(WIDTH)) u_dut (
    .clk      (clk),
    .i_sclr_n (i_sclr_n),
    .i_tc     (i_tc),
    .i_load   (i_load),
    .i_run    (i_run),
    .o_en     (o_en),
    .o_sq     (o_sq),
    .o_cnt    (o_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge; outputs are sampled and inputs driven at the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [WIDTH-1:0] tc);
    i_sclr_n = 1'b0;
    i_tc     = tc;
    i_load   = 1'b0;
    step();
    i_sclr_n = 1'b1;
  endtask

  initial begin
    clk      = 1'b0;
    n_checks = 0;
    n_fail   = 0;
    i_sclr_n = 1'b0;
    i_tc     = 4'd7;
    i_load   = 1'b0;
    i_run    = 1'b1;

    // Reset state and free run, tc=7
    step();
    chk("rst_cnt", 32'(o_cnt), 32'd0);
    chk("rst_sq",  32'(o_sq),  32'd0);
    chk("rst_en",  32'(o_en),  32'd0);
    i_sclr_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("run_cnt", 32'(o_cnt), 32'(i));
      chk("run_en",  32'(o_en),  (i == 7) ? 32'd1 : 32'd0);
      chk("run_sq",  32'(o_sq),  32'd0);
      step();
    end
    chk("run_wrap_cnt", 32'(o_cnt), 32'd0);
    chk("run_wrap_sq",  32'(o_sq),  32'd1);
    chk("run_wrap_en",  32'(o_en),  32'd0);
    step();
    chk("run_after_en", 32'(o_en), 32'd0);

    // Shadow update: tc 5 -> 2 while cnt=2, old period completes
    do_reset(4'd5);
    for (int i = 0; i < 6; i++) begin
      chk("shd_cnt", 32'(o_cnt), 32'(i));
      chk("shd_en",  32'(o_en),  (i == 5) ? 32'd1 : 32'd0);
      if (i == 2) i_tc = 4'd2;
      step();
    end
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 3; i++) begin
        chk("shd_new_cnt", 32'(o_cnt), 32'(i));
        chk("shd_new_en",  32'(o_en),  (i == 2) ? 32'd1 : 32'd0);
        step();
      end
    end

    // Pause at cnt=2 for 3 cycles, tc=4
    do_reset(4'd4);
    for (int i = 0; i < 2; i++) begin
      chk("pau_cnt", 32'(o_cnt), 32'(i));
      step();
    end
    chk("pau_cnt2", 32'(o_cnt), 32'd2);
    i_run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("pau_hold_en", 32'(o_en), 32'd0);
      step();
      chk("pau_hold_cnt", 32'(o_cnt), 32'd2);
    end
    i_run = 1'b1;
    chk("pau_res_en0", 32'(o_en), 32'd0);
    step();
    chk("pau_res_cnt3", 32'(o_cnt), 32'd3);
    chk("pau_res_en3",  32'(o_en),  32'd0);
    step();
    chk("pau_res_cnt4", 32'(o_cnt), 32'd4);
    chk("pau_res_en4",  32'(o_en),  32'd1);

    // Load in the terminal cycle: no toggle, new tc=6 takes effect at once
    do_reset(4'd3);
    for (int i = 0; i < 3; i++) step();
    chk("ld_term_cnt", 32'(o_cnt), 32'd3);
    chk("ld_term_en",  32'(o_en),  32'd1);
    i_load = 1'b1;
    i_tc   = 4'd6;
    step();
    i_load = 1'b0;
    chk("ld_sq_hold", 32'(o_sq), 32'd0);
    for (int i = 0; i < 7; i++) begin
      chk("ld_cnt", 32'(o_cnt), 32'(i));
      chk("ld_en",  32'(o_en),  (i == 6) ? 32'd1 : 32'd0);
      step();
    end
    chk("ld_wrap_sq", 32'(o_sq), 32'd1);

    // Period 1: reset with tc=0, strobe every running cycle
    i_run = 1'b0;
    do_reset(4'd0);
    chk("p1_idle_en", 32'(o_en), 32'd0);
    i_run = 1'b1;
    #1;
    chk("p1_rst_en", 32'(o_en), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("p1_en", 32'(o_en), 32'd1);
      chk("p1_sq", 32'(o_sq), 32'(i % 2));
      step();
    end

    // Full range via load, tc=15
    i_load = 1'b1;
    i_tc   = 4'd15;
    step();
    i_load = 1'b0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 16; i++) begin
        chk("full_cnt", 32'(o_cnt), 32'(i));
        chk("full_en",  32'(o_en),  (i == 15) ? 32'd1 : 32'd0);
        step();
      end
    end
    chk("full_wrap_cnt", 32'(o_cnt), 32'd0);

    // Reset mid-period at cnt=5, tc=7: period discarded
    do_reset(4'd7);
    for (int i = 0; i < 5; i++) step();
    chk("mid_pre_cnt", 32'(o_cnt), 32'd5);
    i_sclr_n = 1'b0;
    step();
    chk("mid_cnt", 32'(o_cnt), 32'd0);
    chk("mid_sq",  32'(o_sq),  32'd0);
    chk("mid_en",  32'(o_en),  32'd0);
    i_sclr_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("mid_run_en", 32'(o_en), (i == 7) ? 32'd1 : 32'd0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/enable_div.md
# enable_div

Programmable clock-enable generator: the parametrised successor of the fixed power-of-two enable generator. It produces a one-cycle `o_en` strobe every `i_tc + 1` cycles, for any period from 1 to 2^WIDTH. The terminal count can be changed at run time without glitching. Counting can be paused, and the block also provides a divided square wave and the live phase count. It sits between the system clock and timing consumers such as pixel/line counters and UART baud ticks, which advance only on `o_en`.

## Interface
- `WIDTH`, default 4: counter and terminal-count width; period range is 1..2^WIDTH cycles.
- `clk` input 1: single clock; all state updates on the rising edge.
- `i_sclr_n` input 1: synchronous, active-low reset; sampled on the rising edge of `clk`.
- `i_tc` input WIDTH: terminal count; period = `i_tc` + 1 cycles.
- `i_load` input 1: restart request; forces the phase to 0 and takes `i_tc` immediately.
- `i_run` input 1: count enable; low = hold phase and suppress `o_en`.
- `o_en` output 1: enable strobe; high for one cycle per period while running.
- `o_sq` output 1: square wave that toggles on every `o_en`; period is 2×(`i_tc`+1) cycles.
- `o_cnt` output WIDTH: current phase count (`cnt`), 0..`tc_q`.

## Operation
- Registered state:
  - `cnt` (WIDTH bits)
  - `tc_q` (WIDTH bits, the active terminal count)
  - `sq` (1 bit)
- Terminal condition: `term` = (`cnt` == `tc_q`).
- `o_en` = `term` & `i_run`. This is combinational from registered state and `i_run`; `i_tc` does not feed it directly.
- `o_cnt` = `cnt`; `o_sq` = `sq`.
- Priority per rising edge, highest first:
  1. `i_sclr_n` = 0: `cnt` ← 0, `tc_q` ← `i_tc`, `sq` ← 0.
  2. `i_load` = 1: `cnt` ← 0, `tc_q` ← `i_tc`. `sq` is unchanged, even if `term` & `i_run` holds this cycle; the load wins and no toggle occurs.
  3. `i_run` = 0: all state holds.
  4. `i_run` = 1 and `term`: `cnt` ← 0, `tc_q` ← `i_tc` (shadow update), `sq` ← ~`sq`.
  5. `i_run` = 1 and not `term`: `cnt` ← `cnt` + 1.
- Shadow update rule: a change on `i_tc` takes effect only at a wrap or a load. The period in progress always completes with its old terminal count, so there are no runt or stretched periods.
- `tc_q` = 0 means period 1: `term` is permanently true and `o_en` = `i_run` every cycle. `sq` then toggles every running cycle.
- `tc_q` = 2^WIDTH−1 is full range. `cnt` wraps by explicit reset to 0, never by arithmetic overflow; modulo arithmetic on `cnt` is not relied upon.
- Because wraps only happen at `cnt` == `tc_q`, `cnt` can never exceed `tc_q`.

## Timing
- Reset values: `o_en` = 1 only if the reset-loaded `tc_q` = 0 and `i_run` = 1, otherwise 0. `o_sq` = 0, `o_cnt` = 0.
- Assume reset is released at edge E0 with `i_run` = 1 and `tc_q` = T:
  - `cnt` = 0 after E0.
  - `o_en` goes high after edge E0+T and stays high for exactly one cycle.
  - It is high again after E0+2T+1, i.e. every T+1 cycles.
- Example, WIDTH=3, T=7: `o_en` is low for 7 cycles after reset release, high for 1, then low for 7.
- Pause: `i_run` low holds `cnt`, and `o_en` drops in the same cycle. When `i_run` returns, counting resumes from the held `cnt`, so the total running cycles per period is unchanged.
- Load: `o_cnt` = 0 in the cycle after the load edge. The next `o_en` occurs `i_tc`+1 running cycles later; with `i_tc` = 0 that is the cycle immediately after the load edge.
- Reset mid-period: the in-flight period is discarded with no `o_en` emitted, and the Operation/Timing reset behaviour applies.
- Latency from an `i_tc` change to the new period: the remainder of the current period, which is ≤ old `tc_q` + 1 cycles.

## Test plan
- **Reset and free run** (WIDTH=3, `i_tc`=7, `i_run`=1): release reset → `o_en` low for 7 cycles, high for 1, low for the next 2 checks; `o_cnt` sequence 0..7,0; `o_sq` toggles to 1 on the cycle after the strobe.
- **Shadow update** (WIDTH=4, `i_tc`=5): change `i_tc` to 2 when `o_cnt`=2 → the current period still ends at `o_cnt`=5 (strobe after 6 cycles); the following strobes come every 3 cycles.
- **Pause**: `i_tc`=4, drop `i_run` for 3 cycles when `o_cnt`=2 → `o_cnt` holds at 2 and `o_en` stays 0 throughout; the strobe arrives 2 running cycles after resume (8 cycles total from `o_cnt`=0).
- **Load vs terminal**: `i_tc`=3, assert `i_load` with `i_tc`=6 in the `term` cycle → `o_sq` does not toggle, `o_cnt`=0 next; the next strobe comes 7 cycles later.
- **Edge periods**: `i_tc`=0 → `o_en`=1 every running cycle and `o_sq` alternates 0/1. `i_tc`=15 (WIDTH=4) → strobe every 16 cycles and `o_cnt` never exceeds 15.
- **Reset mid-operation**: assert `i_sclr_n`=0 at `o_cnt`=5 (`i_tc`=7) → after that edge `o_cnt`=0, `o_sq`=0, `o_en`=0, and no strobe is emitted for that period.
